zmaps_rd: RTL and testbench

- Read-side counterpart of the Z80 FPRAM write mapper.
- Decodes Z80 memory reads that fall in the FPRAM window (CRAM, SFILE, register space) and issues single-port read cycles to CRAM/SFILE.
- Returns the addressed byte to the Z80 data-bus mux.
- Arbitrates the read port against DMA readback, which has priority, and stretches the Z80 cycle via a wait output while the access is pending.

---
 rtl/zmaps_rd_pkg.sv | 27 ++
 rtl/zmaps_rd_if.sv | 27 ++
 rtl/zmaps_rd_lat.sv | 39 +++
 rtl/zmaps_rd.sv | 192 +++++++++++++++++++
 tb/tb_zmaps_rd.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zmaps_rd_pkg.sv
// Shared definitions for the Z80 FPRAM mappers (read and write side):
// window region codes, read FSM encoding and legal RAM latency range.
package zmaps_rd_pkg;

   localparam logic [2:0] REGION_CRAM = 3'b000;
   localparam logic [2:0] REGION_SFIL = 3'b001;
   localparam logic [3:0] REGION_REGS = 4'b0100;

   localparam int RAM_LAT_MIN = 1;
   localparam int RAM_LAT_MAX = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PEND,
      ST_ISSUE,
      ST_LAT,
      ST_DONE
   } rd_state_t;

   typedef enum logic [1:0] {
      TGT_CRAM,
      TGT_SFILE,
      TGT_REGS,
      TGT_OTHER
   } rd_target_t;

endpackage

// File: rtl/zmaps_rd_if.sv
// Single-port read bus shared by CRAM and SFILE. The mapper is the master:
// it drives the word address and the per-RAM read enables, the RAMs return q.
interface zmaps_rd_if;

   logic [7:0]  zra;
   logic        cram_re;
   logic        sfile_re;
   logic [15:0] cram_q;
   logic [15:0] sfile_q;

   modport master (
      output zra,
      output cram_re,
      output sfile_re,
      input  cram_q,
      input  sfile_q
   );

   modport slave (
      input  zra,
      input  cram_re,
      input  sfile_re,
      output cram_q,
      output sfile_q
   );

endinterface

// File: rtl/zmaps_rd_lat.sv
// DEPTH-deep valid/tag shift register. A push emerges on out_valid exactly
// DEPTH cycles later together with its tag, which lines up with the cycle in
// which the RAM read data for that push is valid.
module zmaps_rd_lat
   import zmaps_rd_pkg::*;
#(
   parameter int DEPTH = RAM_LAT_MIN,
   parameter int TAG_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag
);

   logic [DEPTH-1:0]            valid_sr;
   logic [DEPTH-1:0][TAG_W-1:0] tag_sr;

   // Shift valid and tag one stage per cycle; reset empties the pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_sr <= '0;
         tag_sr   <= '0;
      end else begin
         valid_sr[0] <= push;
         tag_sr[0]   <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            valid_sr[i] <= valid_sr[i-1];
            tag_sr[i]   <= tag_sr[i-1];
         end
      end
   end

   assign out_valid = valid_sr[DEPTH-1];
   assign out_tag   = tag_sr[DEPTH-1];

endmodule

// File: rtl/zmaps_rd.sv
// Z80 FPRAM read mapper. Decodes Z80 reads in the FPRAM window, issues a
// single read on the shared CRAM/SFILE port, and stalls the Z80 with zwait
// until the byte is back. DMA readback owns the port whenever it asks.
module zmaps_rd
   import zmaps_rd_pkg::*;
#(
   parameter int         RAM_LAT     = 1,
   parameter logic [7:0] REGS_RD_VAL = 8'hFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              memrd_s,
   input  logic [15:0]       a,
   input  logic [4:0]        fmaddr,
   input  logic [7:0]        dma_rdaddr,
   input  logic              dma_cram_re,
   input  logic              dma_sfile_re,
   zmaps_rd_if.master        ram,
   output logic              zrd_hit,
   output logic [7:0]        zrd_data,
   output logic              zrd_valid,
   output logic              zwait,
   output logic [15:0]       dma_rd_data,
   output logic              dma_rd_valid
);

   rd_state_t  state;
   rd_state_t  state_next;
   rd_target_t dec_target;
   rd_target_t req_target;
   logic       dec_hit;
   logic       accept;
   logic [7:0] req_addr;
   logic       req_byte;
   logic       z_issue;
   logic       z_lat_done;
   logic       z_lat_tag;
   logic [15:0] z_q;
   logic       dma_any;
   logic       dma_sfile_eff;
   logic       dma_lat_valid;
   logic       dma_lat_tag;

   // CRAM wins if both DMA requests show up together.
   assign dma_any       = dma_cram_re | dma_sfile_re;
   assign dma_sfile_eff = dma_sfile_re & ~dma_cram_re;

   // Window decode of the live Z80 address; unassigned window space reads like registers.
   always_comb begin
      dec_hit = fmaddr[4] && (a[15:12] == fmaddr[3:0]);
      if (a[11:9] == REGION_CRAM)
         dec_target = TGT_CRAM;
      else if (a[11:9] == REGION_SFIL)
         dec_target = TGT_SFILE;
      else if (a[11:8] == REGION_REGS)
         dec_target = TGT_REGS;
      else
         dec_target = TGT_OTHER;
   end

   assign accept = (state == ST_IDLE) && memrd_s && dec_hit;

   // Latch the accepted request so later address/fmaddr changes cannot disturb it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_addr   <= 8'h00;
         req_byte   <= 1'b0;
         req_target <= TGT_CRAM;
      end else if (accept) begin
         req_addr   <= a[8:1];
         req_byte   <= a[0];
         req_target <= dec_target;
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Next state and Z80-side handshake; an ISSUE cycle that meets a DMA request backs off to PEND.
   always_comb begin
      state_next = state;
      z_issue    = 1'b0;
      zwait      = 1'b0;
      zrd_hit    = 1'b0;
      zrd_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (dec_target inside {TGT_CRAM, TGT_SFILE})
                  state_next = ST_PEND;
               else
                  state_next = ST_DONE;
            end
         end
         ST_PEND: begin
            zwait   = 1'b1;
            zrd_hit = 1'b1;
            if (!dma_any)
               state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            zwait   = 1'b1;
            zrd_hit = 1'b1;
            if (dma_any) begin
               state_next = ST_PEND;
            end else begin
               z_issue    = 1'b1;
               state_next = ST_LAT;
            end
         end
         ST_LAT: begin
            zwait   = 1'b1;
            zrd_hit = 1'b1;
            if (z_lat_done)
               state_next = ST_DONE;
         end
         ST_DONE: begin
            zrd_hit    = 1'b1;
            zrd_valid  = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Port mux: DMA first, otherwise the Z80 read in its ISSUE cycle.
   always_comb begin
      ram.zra      = 8'h00;
      ram.cram_re  = 1'b0;
      ram.sfile_re = 1'b0;
      if (dma_any) begin
         ram.zra      = dma_rdaddr;
         ram.cram_re  = dma_cram_re;
         ram.sfile_re = dma_sfile_eff;
      end else if (z_issue) begin
         ram.zra      = req_addr;
         ram.cram_re  = (req_target == TGT_CRAM);
         ram.sfile_re = (req_target == TGT_SFILE);
      end
   end

   zmaps_rd_lat #(
      .DEPTH (RAM_LAT),
      .TAG_W (1)
   ) u_z_lat (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (z_issue),
      .tag_in    (req_target == TGT_SFILE),
      .out_valid (z_lat_done),
      .out_tag   (z_lat_tag)
   );

   zmaps_rd_lat #(
      .DEPTH (RAM_LAT),
      .TAG_W (1)
   ) u_dma_lat (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (dma_any),
      .tag_in    (dma_sfile_eff),
      .out_valid (dma_lat_valid),
      .out_tag   (dma_lat_tag)
   );

   assign z_q = z_lat_tag ? ram.sfile_q : ram.cram_q;

   // Z80 byte register: register-space value at accept, RAM byte when the latency pipe drains; holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         zrd_data <= 8'h00;
      else if (accept && !(dec_target inside {TGT_CRAM, TGT_SFILE}))
         zrd_data <= REGS_RD_VAL;
      else if (state == ST_LAT && z_lat_done)
         zrd_data <= req_byte ? z_q[15:8] : z_q[7:0];
   end

   assign dma_rd_valid = dma_lat_valid;
   assign dma_rd_data  = dma_lat_valid ? (dma_lat_tag ? ram.sfile_q : ram.cram_q) : 16'h0000;

   // Protocol checks: latency range, dual DMA request, Z80 strobe while busy, port exclusivity.
   a_lat_range:  assert property (@(posedge clk) (RAM_LAT >= RAM_LAT_MIN) && (RAM_LAT <= RAM_LAT_MAX));
   a_dma_dual:   assert property (@(posedge clk) disable iff (!rst_n) !(dma_cram_re && dma_sfile_re));
   a_memrd_busy: assert property (@(posedge clk) disable iff (!rst_n) !(memrd_s && state != ST_IDLE));
   a_port_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(z_issue && dma_any));

endmodule

// File: tb/tb_zmaps_rd.sv
// Directed self-checking bench for zmaps_rd. Two instances share stimulus:
// dut1 with RAM_LAT=1 and dut3 with RAM_LAT=3, each with its own RAM model.
module tb_zmaps_rd;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memrd_s;
   logic        memrd_s3;
   logic [15:0] a;
   logic [4:0]  fmaddr;
   logic [7:0]  dma_rdaddr;
   logic        dma_cram_re;
   logic        dma_sfile_re;

   logic        zrd_hit1, zrd_valid1, zwait1, dma_rd_valid1;
   logic [7:0]  zrd_data1;
   logic [15:0] dma_rd_data1;
   logic        zrd_hit3, zrd_valid3, zwait3, dma_rd_valid3;
   logic [7:0]  zrd_data3;
   logic [15:0] dma_rd_data3;

   zmaps_rd_if ram1 ();
   zmaps_rd_if ram3 ();

   logic [15:0] cram_mem [256];
   logic [15:0] sfile_mem [256];
   logic [15:0] c1_q, s1_q;
   logic [15:0] c3_p [3];
   logic [15:0] s3_p [3];

   int n_checks = 0;
   int n_fail   = 0;

   int          w_cnt, cre_cnt, sre_cnt, hit_cnt, v_cnt, v_at, dv_cnt, dv_at;
   logic [7:0]  zra_z, v_data, end_data;
   logic [15:0] dv_data [8];

   zmaps_rd #(.RAM_LAT(1), .REGS_RD_VAL(8'hFF)) dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .memrd_s      (memrd_s),
      .a            (a),
      .fmaddr       (fmaddr),
      .dma_rdaddr   (dma_rdaddr),
      .dma_cram_re  (dma_cram_re),
      .dma_sfile_re (dma_sfile_re),
      .ram          (ram1.master),
      .zrd_hit      (zrd_hit1),
      .zrd_data     (zrd_data1),
      .zrd_valid    (zrd_valid1),
      .zwait        (zwait1),
      .dma_rd_data  (dma_rd_data1),
      .dma_rd_valid (dma_rd_valid1)
   );

   zmaps_rd #(.RAM_LAT(3), .REGS_RD_VAL(8'hFF)) dut3 (
      .clk          (clk),
      .rst_n        (rst_n),
      .memrd_s      (memrd_s3),
      .a            (a),
      .fmaddr       (fmaddr),
      .dma_rdaddr   (dma_rdaddr),
      .dma_cram_re  (dma_cram_re),
      .dma_sfile_re (dma_sfile_re),
      .ram          (ram3.master),
      .zrd_hit      (zrd_hit3),
      .zrd_data     (zrd_data3),
      .zrd_valid    (zrd_valid3),
      .zwait        (zwait3),
      .dma_rd_data  (dma_rd_data3),
      .dma_rd_valid (dma_rd_valid3)
   );

   always #5 clk = ~clk;

   // One-cycle-latency RAM pair behind dut1.
   always @(posedge clk) begin
      if (ram1.cram_re)  c1_q <= cram_mem[ram1.zra];
      if (ram1.sfile_re) s1_q <= sfile_mem[ram1.zra];
   end

   // Three-cycle-latency RAM pair behind dut3.
   always @(posedge clk) begin
      if (ram3.cram_re)  c3_p[0] <= cram_mem[ram3.zra];
      if (ram3.sfile_re) s3_p[0] <= sfile_mem[ram3.zra];
      c3_p[1] <= c3_p[0];
      c3_p[2] <= c3_p[1];
      s3_p[1] <= s3_p[0];
      s3_p[2] <= s3_p[1];
   end

   assign ram1.cram_q  = c1_q;
   assign ram1.sfile_q = s1_q;
   assign ram3.cram_q  = c3_p[2];
   assign ram3.sfile_q = s3_p[2];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Runs ncyc cycles from just after a rising edge: memrd pulse in cycle 0,
   // optional DMA burst, and per-cycle observation of the selected instance.
   task automatic applyStimulus(input bit sel3, input logic [15:0] addr, input logic [4:0] fm,
                                input int dma_start, input int dma_n, input logic [7:0] dma_base,
                                input bit dma_sf, input int ncyc);
      logic dma_now;
      w_cnt = 0; cre_cnt = 0; sre_cnt = 0; hit_cnt = 0; v_cnt = 0; v_at = -1;
      dv_cnt = 0; dv_at = -1; zra_z = 8'h00; v_data = 8'h00; end_data = 8'h00;
      for (int c = 0; c < ncyc; c++) begin
         a      = addr;
         fmaddr = fm;
         if (sel3) memrd_s3 = (c == 0);
         else      memrd_s  = (c == 0);
         dma_now = (c >= dma_start) && (c < dma_start + dma_n);
         if (dma_now) begin
            dma_rdaddr   = dma_base + 8'(c - dma_start);
            dma_cram_re  = !dma_sf;
            dma_sfile_re = dma_sf;
         end else begin
            dma_rdaddr   = 8'h00;
            dma_cram_re  = 1'b0;
            dma_sfile_re = 1'b0;
         end
         @(negedge clk);
         if (sel3 ? zwait3 : zwait1) w_cnt++;
         if (sel3 ? zrd_hit3 : zrd_hit1) hit_cnt++;
         if (sel3 ? ram3.cram_re : ram1.cram_re) cre_cnt++;
         if (sel3 ? ram3.sfile_re : ram1.sfile_re) sre_cnt++;
         if (!dma_now && (sel3 ? (ram3.cram_re || ram3.sfile_re) : (ram1.cram_re || ram1.sfile_re)))
            zra_z = sel3 ? ram3.zra : ram1.zra;
         if (sel3 ? zrd_valid3 : zrd_valid1) begin
            v_cnt++;
            v_at   = c;
            v_data = sel3 ? zrd_data3 : zrd_data1;
         end
         if (sel3 ? dma_rd_valid3 : dma_rd_valid1) begin
            if (dv_cnt < 8) dv_data[dv_cnt] = sel3 ? dma_rd_data3 : dma_rd_data1;
            if (dv_at < 0) dv_at = c;
            dv_cnt++;
         end
         end_data = sel3 ? zrd_data3 : zrd_data1;
         @(posedge clk);
         #1;
      end
      memrd_s      = 1'b0;
      memrd_s3     = 1'b0;
      dma_cram_re  = 1'b0;
      dma_sfile_re = 1'b0;
      dma_rdaddr   = 8'h00;
   endtask

   initial begin
      int v1, v3;
      for (int i = 0; i < 256; i++) begin
         cram_mem[i]  = 16'h0000;
         sfile_mem[i] = 16'h0000;
      end
      cram_mem[8'h5A]  = 16'hBEEF;
      sfile_mem[8'h5A] = 16'h1234;
      cram_mem[8'h10]  = 16'h1001;
      cram_mem[8'h11]  = 16'h1102;
      cram_mem[8'h12]  = 16'h1203;
      cram_mem[8'h13]  = 16'h1304;

      rst_n = 1'b0; memrd_s = 1'b0; memrd_s3 = 1'b0; a = 16'h0000; fmaddr = 5'h00;
      dma_rdaddr = 8'h00; dma_cram_re = 1'b0; dma_sfile_re = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_zwait",    32'(zwait1), 0);
      checkOutput("rst_hit",      32'(zrd_hit1), 0);
      checkOutput("rst_data",     32'(zrd_data1), 0);
      checkOutput("rst_valid",    32'(zrd_valid1), 0);
      checkOutput("rst_cram_re",  32'(ram1.cram_re), 0);
      checkOutput("rst_zra",      32'(ram1.zra), 0);
      checkOutput("rst_dma_v",    32'(dma_rd_valid1), 0);
      checkOutput("rst_dma_d",    32'(dma_rd_data1), 0);
      checkOutput("rst_zwait3",   32'(zwait3), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] CRAM high byte read");
      applyStimulus(0, 16'h10B5, 5'h11, 0, 0, 8'h00, 0, 8);
      checkOutput("c_hi_zra",   32'(zra_z), 'h5A);
      checkOutput("c_hi_cre",   cre_cnt, 1);
      checkOutput("c_hi_sre",   sre_cnt, 0);
      checkOutput("c_hi_wait",  w_cnt, 3);
      checkOutput("c_hi_hit",   hit_cnt, 4);
      checkOutput("c_hi_vcnt",  v_cnt, 1);
      checkOutput("c_hi_vat",   v_at, 4);
      checkOutput("c_hi_data",  32'(v_data), 'hBE);
      checkOutput("c_hi_hold",  32'(end_data), 'hBE);

      $display("[TB] CRAM low byte read");
      applyStimulus(0, 16'h10B4, 5'h11, 0, 0, 8'h00, 0, 8);
      checkOutput("c_lo_data",  32'(v_data), 'hEF);
      checkOutput("c_lo_cre",   cre_cnt, 1);

      $display("[TB] SFILE read");
      applyStimulus(0, 16'h12B4, 5'h11, 0, 0, 8'h00, 0, 8);
      checkOutput("s_lo_sre",   sre_cnt, 1);
      checkOutput("s_lo_cre",   cre_cnt, 0);
      checkOutput("s_lo_zra",   32'(zra_z), 'h5A);
      checkOutput("s_lo_data",  32'(v_data), 'h34);

      $display("[TB] unassigned window read");
      applyStimulus(0, 16'h1A00, 5'h11, 0, 0, 8'h00, 0, 6);
      checkOutput("oth_en",     cre_cnt + sre_cnt, 0);
      checkOutput("oth_wait",   w_cnt, 0);
      checkOutput("oth_vat",    v_at, 1);
      checkOutput("oth_data",   32'(v_data), 'hFF);

      $display("[TB] Z80 read behind a DMA burst");
      applyStimulus(0, 16'h10B5, 5'h11, 0, 4, 8'h10, 0, 12);
      checkOutput("burst_wait", w_cnt, 6);
      checkOutput("burst_cre",  cre_cnt, 5);
      checkOutput("burst_zra",  32'(zra_z), 'h5A);
      checkOutput("burst_vat",  v_at, 7);
      checkOutput("burst_data", 32'(v_data), 'hBE);
      checkOutput("burst_dvn",  dv_cnt, 4);
      checkOutput("burst_dvat", dv_at, 1);
      checkOutput("burst_dv0",  32'(dv_data[0]), 'h1001);
      checkOutput("burst_dv1",  32'(dv_data[1]), 'h1102);
      checkOutput("burst_dv2",  32'(dv_data[2]), 'h1203);
      checkOutput("burst_dv3",  32'(dv_data[3]), 'h1304);

      $display("[TB] register space read");
      applyStimulus(0, 16'h1400, 5'h11, 0, 0, 8'h00, 0, 6);
      checkOutput("regs_en",    cre_cnt + sre_cnt, 0);
      checkOutput("regs_wait",  w_cnt, 0);
      checkOutput("regs_vat",   v_at, 1);
      checkOutput("regs_data",  32'(v_data), 'hFF);

      $display("[TB] Z80 and DMA returns in the same cycle");
      applyStimulus(0, 16'h10B4, 5'h11, 3, 1, 8'h5A, 1, 8);
      checkOutput("coll_vat",   v_at, 4);
      checkOutput("coll_dvat",  dv_at, 4);
      checkOutput("coll_data",  32'(v_data), 'hEF);
      checkOutput("coll_dv0",   32'(dv_data[0]), 'h1234);
      checkOutput("coll_sre",   sre_cnt, 1);
      checkOutput("coll_cre",   cre_cnt, 1);

      $display("[TB] window disabled");
      applyStimulus(0, 16'h10B5, 5'h01, 0, 0, 8'h00, 0, 6);
      checkOutput("dis_hit",    hit_cnt, 0);
      checkOutput("dis_en",     cre_cnt + sre_cnt, 0);
      checkOutput("dis_wait",   w_cnt, 0);
      checkOutput("dis_vcnt",   v_cnt, 0);
      checkOutput("dis_hold",   32'(end_data), 'hEF);

      $display("[TB] window page mismatch");
      applyStimulus(0, 16'h20B5, 5'h11, 0, 0, 8'h00, 0, 6);
      checkOutput("pg_hit",     hit_cnt, 0);
      checkOutput("pg_en",      cre_cnt + sre_cnt, 0);
      checkOutput("pg_wait",    w_cnt, 0);

      $display("[TB] reset during LAT");
      a = 16'h10B5; fmaddr = 5'h11; memrd_s = 1'b1; memrd_s3 = 1'b1;
      @(posedge clk); #1;
      memrd_s = 1'b0; memrd_s3 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("mid_wait1",  32'(zwait1), 1);
      checkOutput("mid_wait3",  32'(zwait3), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("ar_wait1",   32'(zwait1), 0);
      checkOutput("ar_hit1",    32'(zrd_hit1), 0);
      checkOutput("ar_data1",   32'(zrd_data1), 0);
      checkOutput("ar_wait3",   32'(zwait3), 0);
      checkOutput("ar_hit3",    32'(zrd_hit3), 0);
      @(negedge clk);
      rst_n = 1'b1;
      v1 = 0; v3 = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (zrd_valid1) v1++;
         if (zrd_valid3) v3++;
      end
      checkOutput("ar_novalid1", v1, 0);
      checkOutput("ar_novalid3", v3, 0);
      @(posedge clk); #1;

      $display("[TB] read after reset");
      applyStimulus(0, 16'h10B4, 5'h11, 0, 0, 8'h00, 0, 8);
      checkOutput("post_data",  32'(v_data), 'hEF);
      checkOutput("post_wait",  w_cnt, 3);

      $display("[TB] RAM_LAT=3 read");
      applyStimulus(1, 16'h10B5, 5'h11, 0, 0, 8'h00, 0, 10);
      checkOutput("l3_wait",    w_cnt, 5);
      checkOutput("l3_vat",     v_at, 6);
      checkOutput("l3_hit",     hit_cnt, 6);
      checkOutput("l3_cre",     cre_cnt, 1);
      checkOutput("l3_zra",     32'(zra_z), 'h5A);
      checkOutput("l3_data",    32'(v_data), 'hBE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
